// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// An action bundles the PC load enable with the per-stage ld/clr vectors.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } pc_state_t;

  // Stage indices into the ld/clr vectors
  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  localparam logic [3:0] B_IFID  = 4'b0001 << IFID;
  localparam logic [3:0] B_IDEX  = 4'b0001 << IDEX;
  localparam logic [3:0] B_EXMEM = 4'b0001 << EXMEM;
  localparam logic [3:0] B_MEMWB = 4'b0001 << MEMWB;
  localparam logic [3:0] B_ALL   = B_IFID | B_IDEX | B_EXMEM | B_MEMWB;

  typedef struct packed {
    logic       pc_ld;
    logic [3:0] ld;
    logic [3:0] clr;
  } act_t;

  localparam act_t ACT_NORMAL  = '{pc_ld: 1'b1, ld: B_ALL,             clr: 4'b0000};
  // Freeze everything and push a bubble into WB while memory stalls
  localparam act_t ACT_MEMWAIT = '{pc_ld: 1'b0, ld: 4'b0000,           clr: B_MEMWB};
  // Let the head of the pipe drain, hold EX, bubble into EX/MEM
  localparam act_t ACT_MCSTALL = '{pc_ld: 1'b0, ld: B_MEMWB,           clr: B_EXMEM};
  // Squash the two wrong-path instructions behind the branch
  localparam act_t ACT_FLUSH   = '{pc_ld: 1'b1, ld: B_ALL,             clr: B_IFID | B_IDEX};
  // Hold PC and IF/ID, bubble into ID/EX
  localparam act_t ACT_LOADUSE = '{pc_ld: 1'b0, ld: B_EXMEM | B_MEMWB, clr: B_IDEX};
  localparam act_t ACT_RESET   = '{pc_ld: 1'b0, ld: 4'b0000,           clr: B_ALL};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the instruction in ID reads a register that the load
// currently in EX will not have written back in time. Register 0 never hazards.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             lu_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
  assign lu_hazard   = ex_mem_read && (ex_rd != '0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: memory wait > multi-cycle stall >
// branch flush > load-use bubble. Outputs are combinational from the
// registered FSM state and the current inputs.
// Build option: PIPE_CTRL_PERF_EN enables the stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int MC_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mc,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_ld,
  output logic [3:0]       ld,
  output logic [3:0]       clr,
  output logic             mc_done,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count
);

  localparam int CW = $clog2(MC_LAT) + 1;

  pc_state_t     r_state;
  logic [CW-1:0] r_mc_cnt;

  logic w_lu_hazard;
  logic w_memwait;
  logic w_mcstall;
  logic w_release;
  logic w_flush;
  act_t w_act;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu_hazard   (w_lu_hazard)
  );

  assign w_memwait = mem_req && !mem_ready;
  assign w_mcstall = ((r_state == RUN) && ex_mc) ||
                     ((r_state == MC_BUSY) && (r_mc_cnt != CW'(1)));
  // A memory wait on the would-be release cycle postpones the release
  assign w_release = rst && !w_memwait && (r_state == MC_BUSY) && (r_mc_cnt == CW'(1));

  // Select the highest-priority action for this cycle
  always_comb begin
    w_act   = ACT_NORMAL;
    w_flush = 1'b0;
    if (!rst) begin
      w_act = ACT_RESET;
    end else if (w_memwait) begin
      w_act = ACT_MEMWAIT;
    end else if (w_mcstall) begin
      w_act = ACT_MCSTALL;
    end else if (ex_branch_taken) begin
      w_act   = ACT_FLUSH;
      w_flush = 1'b1;
    end else if (w_lu_hazard) begin
      w_act = ACT_LOADUSE;
    end
  end

  assign pc_ld   = w_act.pc_ld;
  assign ld      = w_act.ld;
  assign clr     = w_act.clr;
  assign mc_done = w_release;

  // Multi-cycle occupancy FSM; frozen during memory wait cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_mc_cnt <= '0;
    end else if (!w_memwait) begin
      case (r_state)
        RUN: begin
          if (ex_mc) begin
            r_state  <= MC_BUSY;
            r_mc_cnt <= CW'(MC_LAT - 1);
          end
        end
        MC_BUSY: begin
          r_mc_cnt <= r_mc_cnt - CW'(1);
          if (r_mc_cnt == CW'(1)) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state  <= RUN;
          r_mc_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  // Performance counters; both wrap naturally at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_act.pc_ld) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table vectors, hand sequences for the
// multi-cycle/reset corners, then randomized traffic against a reference model.
module tb_pipe_ctrl;

  localparam int REG_W  = 5;
  localparam int MC_LAT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_mc;
  logic             mem_req, mem_ready;
  logic             pc_ld, mc_done;
  logic [3:0]       ld, clr;
  logic [31:0]      stall_cycles;
  logic [15:0]      flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.REG_W(REG_W), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mc(ex_mc),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_ld(pc_ld), .ld(ld), .clr(clr), .mc_done(mc_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Output vector layout: {pc_ld, ld, clr, mc_done}
  localparam logic [9:0] V_NORMAL = {1'b1, 4'b1111, 4'b0000, 1'b0};
  localparam logic [9:0] V_MCST   = {1'b0, 4'b1000, 4'b0100, 1'b0};
  localparam logic [9:0] V_MEMW   = {1'b0, 4'b0000, 4'b1000, 1'b0};
  localparam logic [9:0] V_LU     = {1'b0, 4'b1100, 4'b0010, 1'b0};
  localparam logic [9:0] V_FLUSH  = {1'b1, 4'b1111, 4'b0011, 1'b0};
  localparam logic [9:0] V_RESET  = {1'b0, 4'b0000, 4'b1111, 1'b0};
  localparam logic [9:0] V_REL    = {1'b1, 4'b1111, 4'b0000, 1'b1};

  // ---------------- reference model ----------------
  // A multi-cycle op is modelled as "busy with N stall cycles still owed";
  // the cycle after the last owed stall is the release.
  bit          m_busy;
  int          m_owed;
  logic [31:0] m_stalls;
  logic [15:0] m_flushes;
  logic [9:0]  e_vec;
  bit          e_flush;

  function automatic void model_outputs();
    bit memwait, lu, mcstall, release_now;
    memwait = mem_req && !mem_ready;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    mcstall = m_busy ? (m_owed > 0) : ex_mc;
    release_now = m_busy && (m_owed == 0) && !memwait;
    e_flush = 1'b0;
    if (!rst)                 e_vec = V_RESET;
    else if (memwait)         e_vec = V_MEMW;
    else if (mcstall)         e_vec = V_MCST;
    else if (ex_branch_taken) begin e_vec = V_FLUSH; e_flush = 1'b1; end
    else if (lu)              e_vec = V_LU;
    else                      e_vec = V_NORMAL;
    if (rst && release_now) e_vec[0] = 1'b1;
  endfunction

  function automatic void model_advance();
    if (!rst) begin
      m_busy = 0; m_owed = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e_vec[9]) m_stalls = m_stalls + 1;
      if (e_flush)   m_flushes = m_flushes + 1;
      if (!(mem_req && !mem_ready)) begin
        if (!m_busy) begin
          if (ex_mc) begin m_busy = 1; m_owed = MC_LAT - 2; end
        end else if (m_owed == 0) m_busy = 0;
        else m_owed = m_owed - 1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0; ex_mc = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // One clock: inputs already driven at posedge+1; sample at negedge.
  task automatic run_cycle(input string name, input bit use_exp, input logic [9:0] exp);
    logic [31:0] exp_sc;
    logic [15:0] exp_fc;
    model_outputs();
    @(negedge clk);
    chk(name, {pc_ld, ld, clr, mc_done}, use_exp ? exp : e_vec);
`ifdef PIPE_CTRL_PERF_EN
    exp_sc = rst ? m_stalls : 32'd0;
    exp_fc = rst ? m_flushes : 16'd0;
`else
    exp_sc = 32'd0;
    exp_fc = 16'd0;
`endif
    chk({name, "_cnt"}, {stall_cycles, flush_count}, {exp_sc, exp_fc});
    $display("cyc %-12s pc_ld=%b ld=%b clr=%b done=%b stalls=%0d flushes=%0d",
             name, pc_ld, ld, clr, mc_done, stall_cycles, flush_count);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    string      name;
    logic       mreq, mrdy, br, mr, u1, u2;
    logic [4:0] rd, rs1, rs2;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input string n, input logic mreq, mrdy, br, mr, u1, u2,
                         input logic [4:0] rd, rs1, rs2, input logic [9:0] exp);
    vec_t v;
    v.name = n; v.mreq = mreq; v.mrdy = mrdy; v.br = br; v.mr = mr;
    v.u1 = u1; v.u2 = u2; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec("idle",       0, 0, 0, 0, 0, 0,  0,  0,  0, V_NORMAL);
    add_vec("memwait",    1, 0, 0, 0, 0, 0,  0,  0,  0, V_MEMW);
    add_vec("memready",   1, 1, 0, 0, 0, 0,  0,  0,  0, V_NORMAL);
    add_vec("lu_rs1",     0, 0, 0, 1, 1, 0,  5,  5,  0, V_LU);
    add_vec("lu_rs2",     0, 0, 0, 1, 0, 1,  7,  3,  7, V_LU);
    add_vec("lu_unused",  0, 0, 0, 1, 0, 0,  5,  5,  5, V_NORMAL);
    add_vec("lu_rd0",     0, 0, 0, 1, 1, 1,  0,  0,  0, V_NORMAL);
    add_vec("no_load",    0, 0, 0, 0, 1, 1,  5,  5,  5, V_NORMAL);
    add_vec("branch",     0, 0, 1, 0, 0, 0,  0,  0,  0, V_FLUSH);
    add_vec("br_over_lu", 0, 0, 1, 1, 1, 0,  5,  5,  0, V_FLUSH);
    add_vec("mw_over_br", 1, 0, 1, 1, 1, 0,  5,  5,  0, V_MEMW);
  end

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    rst = 1'b0;
    m_busy = 0; m_owed = 0; m_stalls = 0; m_flushes = 0;
    #1;
    run_cycle("reset0", 1, V_RESET);
    run_cycle("reset1", 1, V_RESET);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      idle_inputs();
      mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      ex_branch_taken = vecs[i].br; ex_mem_read = vecs[i].mr;
      id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2;
      ex_rd = vecs[i].rd; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      run_cycle(vecs[i].name, 1, vecs[i].exp);
    end

    // Load-use costs one bubble, then the load has moved on
    idle_inputs(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    run_cycle("lu_bubble", 1, V_LU);
    ex_mem_read = 0;
    run_cycle("lu_after", 1, V_NORMAL);

    // Multi-cycle op: MC_LAT-1 stalls then release
    idle_inputs(); ex_mc = 1;
    run_cycle("mc_t0", 1, V_MCST);
    run_cycle("mc_t1", 1, V_MCST);   // ex_mc still high, ignored while busy
    ex_mc = 0;
    run_cycle("mc_t2", 1, V_MCST);
    run_cycle("mc_rel", 1, V_REL);
    run_cycle("mc_after", 1, V_NORMAL);

    // Memory wait inside the op pushes the release out one cycle
    ex_mc = 1;
    run_cycle("mcw_t0", 1, V_MCST);
    ex_mc = 0; mem_req = 1; mem_ready = 0;
    run_cycle("mcw_wait", 1, V_MEMW);
    mem_req = 0;
    run_cycle("mcw_t2", 1, V_MCST);
    run_cycle("mcw_t3", 1, V_MCST);
    mem_req = 1; mem_ready = 0;
    run_cycle("mcw_relw", 1, V_MEMW);  // wait on the release cycle
    mem_req = 0; ex_branch_taken = 1;
    run_cycle("mcw_relbr", 1, {V_FLUSH[9:1], 1'b1});
    ex_branch_taken = 0;
    run_cycle("mcw_after", 1, V_NORMAL);

    // Asynchronous reset mid-op (two stall cycles already taken)
    ex_mc = 1;
    run_cycle("rmc_t0", 1, V_MCST);
    ex_mc = 0;
    run_cycle("rmc_t1", 1, V_MCST);
    rst = 1'b0;
    #1;
    chk("rst_async", {pc_ld, ld, clr, mc_done}, V_RESET);
    chk("rst_async_cnt", {stall_cycles, flush_count}, 48'd0);
    #(-1 + 1);
    run_cycle("rmc_hold", 1, V_RESET);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle("rmc_post", 1, V_NORMAL);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      mem_req         = ($urandom % 5) == 0;
      mem_ready       = $urandom % 2;
      ex_mc           = ($urandom % 9) == 0;
      ex_branch_taken = ($urandom % 6) == 0;
      ex_mem_read     = ($urandom % 3) == 0;
      ex_rd           = REG_W'($urandom % 4);
      id_rs1          = REG_W'($urandom % 4);
      id_rs2          = REG_W'($urandom % 4);
      id_use_rs1      = $urandom % 2;
      id_use_rs2      = $urandom % 2;
      rst             = ($urandom % 150) != 0;
      run_cycle("rand", 0, 10'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
